// File: rtl/snake_engine_if.sv
// Bus between the snake core and its surroundings: step/buttons/food/readout in,
// head/length/status/row occupancy out.
interface snake_engine_if #(
  parameter int COLS    = 16,
  parameter int ROWS    = 8,
  parameter int MAX_LEN = 32
);
  localparam int XW = $clog2(COLS);
  localparam int YW = $clog2(ROWS);
  localparam int LW = $clog2(MAX_LEN + 1);

  logic          tick;
  logic          btnUp;
  logic          btnDown;
  logic          btnLeft;
  logic          btnRight;
  logic [XW-1:0] foodX;
  logic [YW-1:0] foodY;
  logic [YW-1:0] row_sel;
  logic [COLS-1:0] row_bits;
  logic [XW-1:0] head_x;
  logic [YW-1:0] head_y;
  logic [LW-1:0] length;
  logic          eat;
  logic          game_over;
  logic          busy;

  modport master (
    output tick, btnUp, btnDown, btnLeft, btnRight, foodX, foodY, row_sel,
    input  row_bits, head_x, head_y, length, eat, game_over, busy
  );

  modport slave (
    input  tick, btnUp, btnDown, btnLeft, btnRight, foodX, foodY, row_sel,
    output row_bits, head_x, head_y, length, eat, game_over, busy
  );
endinterface

// File: rtl/snake_engine.sv
// Snake game core: ring-buffer body, occupancy bitmap, tick-stepped movement and
// collision. Define SNAKE_WRAP_EN to make the walls wrap instead of ending the game.
module snake_engine #(
  parameter int COLS     = 16,
  parameter int ROWS     = 8,
  parameter int MAX_LEN  = 32,
  parameter int INIT_LEN = 3
) (
  input logic           clk,
  input logic           reset,
  snake_engine_if.slave bus
);
  localparam int XW = $clog2(COLS);
  localparam int YW = $clog2(ROWS);
  localparam int LW = $clog2(MAX_LEN + 1);
  localparam int PW = $clog2(MAX_LEN);
  localparam int CW = XW + YW;

  typedef enum logic [1:0] {S_INIT, S_RUN, S_MOVE, S_OVER} state_t;
  // Encoding chosen so opposite directions differ only in bit 0.
  typedef enum logic [1:0] {D_UP, D_DOWN, D_LEFT, D_RIGHT} dir_t;

  state_t          r_state, w_state_nx;
  dir_t            r_dir, w_req;
  logic            w_req_vld, w_rev;

  logic [XW-1:0]   r_bx [MAX_LEN];
  logic [YW-1:0]   r_by [MAX_LEN];
  logic [PW-1:0]   r_hptr, r_tptr;
  logic [COLS*ROWS-1:0] r_map;
  logic [XW-1:0]   r_hx;
  logic [YW-1:0]   r_hy;
  logic [LW-1:0]   r_len;
  logic            r_eat;
  logic [COLS-1:0] r_row;
  logic [3:0]      r_btn_prev;

  logic [3:0]      w_btn;
  logic            w_btn_rise;
  logic [XW-1:0]   w_nx, w_ix, w_wr_x;
  logic [YW-1:0]   w_ny, w_wr_y;
  logic [CW-1:0]   w_ncell, w_tcell, w_icell;
  logic            w_edge, w_off, w_grow, w_hit, w_die, w_len_inc;
  logic            w_init_last, w_wr_en;

  assign w_btn      = {bus.btnUp, bus.btnDown, bus.btnLeft, bus.btnRight};
  assign w_btn_rise = |(w_btn & ~r_btn_prev);

  always_comb begin
    w_req_vld = 1'b1;
    w_req     = D_RIGHT;
    if (bus.btnUp)         w_req = D_UP;
    else if (bus.btnDown)  w_req = D_DOWN;
    else if (bus.btnLeft)  w_req = D_LEFT;
    else if (bus.btnRight) w_req = D_RIGHT;
    else                   w_req_vld = 1'b0;
  end

  assign w_rev = ((w_req ^ r_dir) == 2'b01);

  always_comb begin
    w_nx   = r_hx;
    w_ny   = r_hy;
    w_edge = 1'b0;
    case (r_dir)
      D_UP: begin
        w_ny   = r_hy - YW'(1);
        w_edge = (r_hy == '0);
      end
      D_DOWN: begin
        w_ny   = r_hy + YW'(1);
        w_edge = (r_hy == YW'(ROWS - 1));
      end
      D_LEFT: begin
        w_nx   = r_hx - XW'(1);
        w_edge = (r_hx == '0);
      end
      default: begin
        w_nx   = r_hx + XW'(1);
        w_edge = (r_hx == XW'(COLS - 1));
      end
    endcase
  end

`ifdef SNAKE_WRAP_EN
  assign w_off = 1'b0;
`else
  assign w_off = w_edge;
`endif

  // Food ports are exactly XW/YW wide, so any food value lies inside the grid.
  assign w_ncell   = {w_ny, w_nx};
  assign w_tcell   = {r_by[r_tptr], r_bx[r_tptr]};
  assign w_grow    = (w_nx == bus.foodX) && (w_ny == bus.foodY);
  assign w_hit     = r_map[w_ncell] && !((w_ncell == w_tcell) && !w_grow);
  assign w_die     = w_off || w_hit;
  assign w_len_inc = w_grow && (r_len < LW'(MAX_LEN));

  assign w_ix        = XW'(r_len);
  assign w_icell     = {YW'(ROWS / 2), w_ix};
  assign w_init_last = (r_len == LW'(INIT_LEN - 1));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= S_INIT;
    else        r_state <= w_state_nx;
  end

  always_comb begin
    w_state_nx = r_state;
    case (r_state)
      S_INIT: if (w_init_last) w_state_nx = S_RUN;
      S_RUN:  if (bus.tick)    w_state_nx = S_MOVE;
      S_MOVE: w_state_nx = w_die ? S_OVER : S_RUN;
      S_OVER: if (w_btn_rise)  w_state_nx = S_INIT;
      default: w_state_nx = S_INIT;
    endcase
  end

  assign w_wr_en = (r_state == S_INIT) || ((r_state == S_MOVE) && !w_die);
  assign w_wr_x  = (r_state == S_INIT) ? w_ix : w_nx;
  assign w_wr_y  = (r_state == S_INIT) ? YW'(ROWS / 2) : w_ny;

  // Body storage holds no reset: only slots between the pointers are ever read.
  always_ff @(posedge clk) begin
    if (w_wr_en) begin
      r_bx[r_hptr] <= w_wr_x;
      r_by[r_hptr] <= w_wr_y;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_dir      <= D_RIGHT;
      r_hptr     <= '0;
      r_tptr     <= '0;
      r_map      <= '0;
      r_hx       <= '0;
      r_hy       <= '0;
      r_len      <= '0;
      r_eat      <= 1'b0;
      r_row      <= '0;
      r_btn_prev <= '0;
    end else begin
      r_eat      <= 1'b0;
      r_btn_prev <= w_btn;
      r_row      <= r_map[{bus.row_sel, {XW{1'b0}}} +: COLS];
      case (r_state)
        S_INIT: begin
          r_dir          <= D_RIGHT;
          r_map[w_icell] <= 1'b1;
          r_hx           <= w_ix;
          r_hy           <= YW'(ROWS / 2);
          r_hptr         <= r_hptr + PW'(1);
          r_len          <= r_len + LW'(1);
        end
        S_RUN: if (w_req_vld && !w_rev) r_dir <= w_req;
        S_MOVE: if (!w_die) begin
          if (w_len_inc) begin
            r_len <= r_len + LW'(1);
          end else begin
            r_map[w_tcell] <= 1'b0;
            r_tptr         <= r_tptr + PW'(1);
          end
          // Set after the tail clear so stepping onto the old tail keeps the bit.
          r_map[w_ncell] <= 1'b1;
          r_hptr         <= r_hptr + PW'(1);
          r_hx           <= w_nx;
          r_hy           <= w_ny;
          r_eat          <= w_grow;
        end
        S_OVER: if (w_btn_rise) begin
          r_map  <= '0;
          r_hptr <= '0;
          r_tptr <= '0;
          r_len  <= '0;
        end
        default: ;
      endcase
    end
  end

  assign bus.row_bits  = r_row;
  assign bus.head_x    = r_hx;
  assign bus.head_y    = r_hy;
  assign bus.length    = r_len;
  assign bus.eat       = r_eat;
  assign bus.game_over = (r_state == S_OVER);
  assign bus.busy      = (r_state == S_INIT) || (r_state == S_MOVE);
endmodule

// File: tb/tb_snake_engine.sv
// Directed bench for snake_engine: each tick step pushes its expected outcome to a
// scoreboard queue that is popped and checked once the move has committed.
module tb_snake_engine;
  localparam int COLS = 16, ROWS = 8, MAX_LEN = 32, INIT_LEN = 3;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  snake_engine_if #(.COLS(COLS), .ROWS(ROWS), .MAX_LEN(MAX_LEN)) bus ();

  snake_engine #(.COLS(COLS), .ROWS(ROWS), .MAX_LEN(MAX_LEN), .INIT_LEN(INIT_LEN)) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  typedef struct {
    string tag;
    int hx, hy, len, eat, over;
  } exp_t;

  exp_t q[$];
  int total = 0;
  int bad   = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic step(input string tag, input int hx, input int hy, input int len,
                      input int eat, input int over);
    exp_t e;
    e.tag = tag; e.hx = hx; e.hy = hy; e.len = len; e.eat = eat; e.over = over;
    q.push_back(e);
    bus.tick = 1'b1;
    cyc();
    bus.tick = 1'b0;
    cyc();
    e = q.pop_front();
    chk({e.tag, ".hx"},   32'(bus.head_x),    e.hx);
    chk({e.tag, ".hy"},   32'(bus.head_y),    e.hy);
    chk({e.tag, ".len"},  32'(bus.length),    e.len);
    chk({e.tag, ".eat"},  32'(bus.eat),       e.eat);
    chk({e.tag, ".over"}, 32'(bus.game_over), e.over);
  endtask

  // One cycle later: registered row readout, and eat must have dropped again.
  task automatic rowchk(input string tag, input int y, input int bits);
    bus.row_sel = 3'(y);
    cyc();
    chk({tag, ".row"},    32'(bus.row_bits), bits);
    chk({tag, ".eatoff"}, 32'(bus.eat),      0);
  endtask

  task automatic press(input int b);
    case (b)
      0: bus.btnUp = 1'b1;
      1: bus.btnDown = 1'b1;
      2: bus.btnLeft = 1'b1;
      default: bus.btnRight = 1'b1;
    endcase
    cyc();
    bus.btnUp = 1'b0; bus.btnDown = 1'b0; bus.btnLeft = 1'b0; bus.btnRight = 1'b0;
    cyc();
  endtask

  initial begin
    reset = 1'b0;
    bus.tick = 1'b0;
    bus.btnUp = 1'b0; bus.btnDown = 1'b0; bus.btnLeft = 1'b0; bus.btnRight = 1'b0;
    bus.foodX = 4'd10;
    bus.foodY = 3'd0;
    bus.row_sel = 3'd4;
    cyc();
    cyc();
    chk("rst.hx",   32'(bus.head_x),    0);
    chk("rst.hy",   32'(bus.head_y),    0);
    chk("rst.len",  32'(bus.length),    0);
    chk("rst.eat",  32'(bus.eat),       0);
    chk("rst.over", 32'(bus.game_over), 0);
    chk("rst.busy", 32'(bus.busy),      1);
    chk("rst.row",  32'(bus.row_bits),  0);

    reset = 1'b1;
    cyc(); cyc(); cyc();
    chk("init.len",  32'(bus.length), 3);
    chk("init.hx",   32'(bus.head_x), 2);
    chk("init.hy",   32'(bus.head_y), 4);
    chk("init.busy", 32'(bus.busy),   0);
    rowchk("init", 4, 16'h0007);

    for (int i = 1; i <= 5; i++) step("right", 2 + i, 4, 3, 0, 0);
    rowchk("right", 4, 16'h00E0);

    bus.foodX = 4'd8; bus.foodY = 3'd4;
    step("eat", 8, 4, 4, 1, 0);
    bus.foodX = 4'd10; bus.foodY = 3'd0;
    rowchk("eat", 4, 16'h01E0);

    press(2);
    step("rev", 9, 4, 4, 0, 0);
    rowchk("rev", 4, 16'h03C0);

    press(0);
    step("up", 9, 3, 4, 0, 0);
    rowchk("up", 4, 16'h0380);

    press(2);
    step("loopL", 8, 3, 4, 0, 0);
    press(1);
    step("ontail", 8, 4, 4, 0, 0);
    rowchk("ontail", 4, 16'h0300);

    press(3);
    for (int x = 9; x <= 15; x++) step("run", x, 4, 4, 0, 0);
    rowchk("run", 4, 16'hF000);

    bus.btnRight = 1'b1;
`ifdef SNAKE_WRAP_EN
    step("wall", 0, 4, 4, 0, 0);
    bus.btnRight = 1'b0;
    rowchk("wall", 4, 16'hE001);
`else
    step("wall", 15, 4, 4, 0, 1);
    step("overtick", 15, 4, 4, 0, 1);
    bus.btnRight = 1'b0;
    cyc();
    chk("held.over", 32'(bus.game_over), 1);
    bus.btnDown = 1'b1;
    cyc();
    chk("restart.busy", 32'(bus.busy),      1);
    chk("restart.over", 32'(bus.game_over), 0);
    chk("restart.len0", 32'(bus.length),    0);
    bus.btnDown = 1'b0;
    cyc(); cyc(); cyc();
    chk("restart.len",  32'(bus.length), 3);
    chk("restart.hx",   32'(bus.head_x), 2);
    chk("restart.hy",   32'(bus.head_y), 4);
    chk("restart.busy1", 32'(bus.busy),  0);
    rowchk("restart", 4, 16'h0007);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/snake_engine.md
# snake_engine

Parametrised snake game core: owns movement, direction latching, the body ring buffer, growth on food, and collision detection on a COLS×ROWS grid, clocked by one `clk` and stepped by a `tick` strobe. It sits between the button inputs and food generator on one side and the matrix display driver on the other. It exposes an occupancy row readout so the display can scan the body directly. It replaces per-move FIFO push/pop with a fully synchronous buffer plus occupancy bitmap.

## Interface
- `COLS`, default 16: grid width; power of two, at least 4.
- `ROWS`, default 8: grid height; power of two, at least 4.
- `MAX_LEN`, default 32: maximum body length; power of two, at most COLS*ROWS.
- `INIT_LEN`, default 3: length after reset or restart; 2..MAX_LEN, at most COLS.
- Width rules: XW=$clog2(COLS), YW=$clog2(ROWS), LW=$clog2(MAX_LEN+1).
- `clk`, input, 1: system clock.
- `reset`, input, 1: asynchronous, active-low reset.
- `tick`, input, 1: one-cycle step strobe.
- `btnUp`, `btnDown`, `btnLeft`, `btnRight`, input, 1 each: direction requests, level, already synchronised.
- `foodX`, input, XW: food column.
- `foodY`, input, YW: food row.
- `row_sel`, input, YW: row to read back.
- `row_bits`, output, COLS: occupancy of `row_sel`; bit i is column i.
- `head_x`, output, XW: head column.
- `head_y`, output, YW: head row.
- `length`, output, LW: current segment count.
- `eat`, output, 1: one-cycle pulse when the head lands on food.
- `game_over`, output, 1: high while in OVER.
- `busy`, output, 1: high in INIT and MOVE.

## Operation
- FSM states:
  - INIT, entered at reset and on restart.
  - RUN, waiting for `tick`.
  - MOVE, one cycle to evaluate and commit a step.
  - OVER, game ended.
- Storage:
  - Body ring buffer: MAX_LEN entries of {x,y}, with head and tail pointers that wrap modulo MAX_LEN.
  - Occupancy bitmap: COLS*ROWS bits.
- INIT:
  - Clears the bitmap.
  - Writes one segment per cycle, i = 0..INIT_LEN-1, at (i, ROWS/2).
  - Each write sets the bitmap bit, advances the head, and increments `length`.
  - Direction is set to RIGHT.
  - After INIT_LEN cycles the FSM goes to RUN.
- Direction latch:
  - Sampled every cycle in RUN.
  - Priority when several buttons are pressed: up > down > left > right.
  - A request for the exact reverse of the current direction is ignored.
  - Only the last latched value before MOVE applies.
- RUN: `tick` high goes to MOVE; `tick` is ignored in every other state.
- MOVE, next-head computation:
  - next = head + direction; y=0 is the top row, so up means y-1.
  - grow = (next == food) and food is inside the grid.
  - hit = bitmap[next] and not (next == tail and not grow).
  - Leaving the grid, or hit, goes to OVER with no buffer or bitmap change.
- MOVE, commit:
  - Write next at the head and set its bitmap bit.
  - If not grow, clear the tail bit and advance the tail.
  - If grow and `length` < MAX_LEN, increment `length` and keep the tail.
  - If grow and `length` == MAX_LEN, behave as not grow (length saturates); `eat` still pulses.
  - Return to RUN.
- OVER:
  - State is frozen.
  - A rising edge on any button goes to INIT (restart).
  - A button already held on entry must be released first.
- Food inputs outside the grid are ignored; no `eat` pulse.

## Timing
- Reset values:
  - State INIT at segment index 0, direction RIGHT.
  - `head_x`=0, `head_y`=0, `length`=0, `eat`=0, `game_over`=0, `busy`=1, `row_bits`=0.
  - Bitmap cleared; both pointers 0.
- INIT takes exactly INIT_LEN cycles. `busy` falls on the first RUN cycle.
- Step latency:
  - `tick` sampled high in RUN at cycle N; MOVE occupies cycle N+1.
  - New `head_x`, `head_y`, `length`, and `eat` (or `game_over`) are visible from cycle N+2.
  - `eat` lasts exactly one cycle.
- `tick` during INIT, MOVE, or OVER is dropped; it is not queued.
- Readout: `row_bits` is registered and reflects `row_sel` and the bitmap as of the previous cycle (1-cycle latency).
- Reset asserted mid-MOVE or mid-INIT:
  - Immediate return to reset values.
  - No partial buffer write is observable after release.

## Configuration
- `SNAKE_WRAP_EN`:
  - Defined: walls wrap. x = COLS-1 plus RIGHT gives 0, y = 0 plus UP gives ROWS-1, by natural XW/YW modulo arithmetic. Only self-collision ends the game.
  - Undefined: any step off the grid goes to OVER.

## Test plan
- Reset, then release with defaults → after 3 cycles `length`=3, head (2,4), `busy`=0; row_sel=4 gives `row_bits`=16'h0007 one cycle later.
- 5 ticks heading right, no food → head (7,4), `length`=3, `row_bits`[row 4]=16'h00E0, no `eat`.
- Food at (3,4), one tick → `eat` pulse at N+2, `length`=4, row 4 = 16'h000F.
- Press btnLeft while heading right, then tick → reversal ignored, head (3,4); press btnUp, tick → head (3,3).
- Drive head into column 15 and tick once more: undefined `SNAKE_WRAP_EN` gives `game_over`=1 with head unchanged; defined gives head (0,4) and `game_over`=0.
- Length 4 in a 2×2 loop where the next cell is the tail → legal move, no `game_over`. From OVER, press then release btnDown → INIT, `length` back to 3.
